branch_resolve_queue: RTL and testbench

Buffers resolved branch outcomes taken from the common data bus (CDB) and trains the 2-bit direction predictor with at most one outcome per cycle. It sits between the CDB broadcast and the predictor's `branch_taken` / `branch_not_taken` inputs. It also detects mispredictions at capture time and issues a registered fetch redirect. Resolved branches are never lost while there is queue space; overflow drops are counted.

---
 rtl/branch_resolve_queue_pkg.sv | 20 ++
 rtl/branch_resolve_queue_fifo.sv | 62 ++++++
 rtl/branch_resolve_queue.sv | 84 ++++++++
 tb/tb_branch_resolve_queue.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// Shared branch-unit definitions: queue entry layout, instruction size and
// the 2-bit direction predictor state encoding.
package branch_pkg;

   localparam int unsigned BR_XLEN       = 32;
   localparam int unsigned BR_INSN_BYTES = 4;

   typedef struct packed {
      logic [BR_XLEN-1:0] pc;
      logic               taken;
   } br_entry_t;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } br_pred_state_e;

endpackage

// File: rtl/branch_resolve_queue_fifo.sv
// Parameterised synchronous FIFO; a pop frees the slot for a same-cycle push
// when full. Storage is not reset.
module br_fifo #(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       din_i,
   output logic [WIDTH-1:0]       dout_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [PW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (PW+1)'(DEPTH));
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rd_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (PW+1)'(1);
         2'b01:   cnt_d = cnt_q - (PW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !rst_i) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/branch_resolve_queue.sv
// Buffers resolved CDB branch outcomes for predictor training, counts
// overflow drops and raises a registered fetch redirect on misprediction.
module branch_resolve_queue
   import branch_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNTW  = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   cdb_valid,
   input  logic                   cdb_is_branch,
   input  logic                   cdb_taken,
   input  logic                   cdb_pred_taken,
   input  logic [XLEN-1:0]        cdb_pc,
   input  logic [XLEN-1:0]        cdb_target,
   input  logic                   upd_ready,
   output logic                   upd_valid,
   output logic [XLEN-1:0]        upd_pc,
   output logic                   branch_taken,
   output logic                   branch_not_taken,
   output logic                   mispredict,
   output logic [XLEN-1:0]        redirect_pc,
   output logic [$clog2(DEPTH):0] count,
   output logic [CNTW-1:0]        drop_count
);

   logic            cap, deq, full, empty, drop;
   logic [XLEN:0]   head;
   logic            mis_q, mis_d;
   logic [XLEN-1:0] red_q, red_d;
   logic [CNTW-1:0] drop_q, drop_d;

   assign cap  = cdb_valid & cdb_is_branch;
   assign deq  = upd_valid & upd_ready;
   assign drop = cap & full & ~deq;

   br_fifo #(
      .WIDTH (XLEN + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clock),
      .rst_i   (reset),
      .push_i  (cap),
      .pop_i   (deq),
      .din_i   ({cdb_pc, cdb_taken}),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   assign upd_valid        = ~empty;
   assign upd_pc           = head[XLEN:1];
   assign branch_taken     = upd_valid &  head[0];
   assign branch_not_taken = upd_valid & ~head[0];

   // Redirect is evaluated regardless of fullness, so dropped entries still redirect.
   always_comb begin
      mis_d  = cap & (cdb_taken != cdb_pred_taken);
      red_d  = red_q;
      drop_d = drop_q;
      if (mis_d) red_d = cdb_taken ? cdb_target : cdb_pc + XLEN'(BR_INSN_BYTES);
      if (drop && drop_q != '1) drop_d = drop_q + CNTW'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mis_q  <= 1'b0;
         red_q  <= '0;
         drop_q <= '0;
      end else begin
         mis_q  <= mis_d;
         red_q  <= red_d;
         drop_q <= drop_d;
      end
   end

   assign mispredict  = mis_q;
   assign redirect_pc = red_q;
   assign drop_count  = drop_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_branch_resolve_queue;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNTW  = 8;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;
   localparam int          DSAT  = (1 << CNTW) - 1;

   logic            clock, reset;
   logic            cdb_valid, cdb_is_branch, cdb_taken, cdb_pred_taken;
   logic [XLEN-1:0] cdb_pc, cdb_target;
   logic            upd_ready;
   logic            upd_valid, branch_taken, branch_not_taken, mispredict;
   logic [XLEN-1:0] upd_pc, redirect_pc;
   logic [CW-1:0]   count;
   logic [CNTW-1:0] drop_count;

   int n_tests = 0;
   int n_fail  = 0;

   branch_resolve_queue #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH),
      .CNTW  (CNTW)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .cdb_valid        (cdb_valid),
      .cdb_is_branch    (cdb_is_branch),
      .cdb_taken        (cdb_taken),
      .cdb_pred_taken   (cdb_pred_taken),
      .cdb_pc           (cdb_pc),
      .cdb_target       (cdb_target),
      .upd_ready        (upd_ready),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .branch_taken     (branch_taken),
      .branch_not_taken (branch_not_taken),
      .mispredict       (mispredict),
      .redirect_pc      (redirect_pc),
      .count            (count),
      .drop_count       (drop_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: an ordered list of outcomes, capped at DEPTH.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic            taken;
   } ent_t;

   ent_t            mq[$];
   int              m_drop;
   logic            m_mis;
   logic [XLEN-1:0] m_red;

   task automatic drive(input logic v, input logic br, input logic t, input logic p,
                        input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                        input logic rdy);
      cdb_valid      = v;
      cdb_is_branch  = br;
      cdb_taken      = t;
      cdb_pred_taken = p;
      cdb_pc         = pc;
      cdb_target     = tgt;
      upd_ready      = rdy;
   endtask

   task automatic tick();
      bit   cap, deq;
      ent_t e;
      @(posedge clock);
      if (reset) begin
         mq.delete();
         m_drop = 0;
         m_mis  = 1'b0;
         m_red  = '0;
      end else begin
         cap = cdb_valid && cdb_is_branch;
         deq = (mq.size() > 0) && upd_ready;
         if (deq) void'(mq.pop_front());
         if (cap) begin
            if (mq.size() < DEPTH) begin
               e.pc    = cdb_pc;
               e.taken = cdb_taken;
               mq.push_back(e);
            end else if (m_drop < DSAT) begin
               m_drop++;
            end
         end
         m_mis = cap && (cdb_taken != cdb_pred_taken);
         if (m_mis) m_red = cdb_taken ? cdb_target : cdb_pc + 32'd4;
      end
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1, 1, 1, 0, 32'h55, 32'h77, 1);
      tick();
      tick();
      reset = 1'b0;
      drive(0, 0, 0, 0, '0, '0, 0);
      n_tests++; if (upd_valid !== 1'b0)        begin n_fail++; $display("FAIL reset_upd_valid got %0b want 0", upd_valid); end
      n_tests++; if (branch_taken !== 1'b0)     begin n_fail++; $display("FAIL reset_branch_taken got %0b want 0", branch_taken); end
      n_tests++; if (branch_not_taken !== 1'b0) begin n_fail++; $display("FAIL reset_branch_not_taken got %0b want 0", branch_not_taken); end
      n_tests++; if (mispredict !== 1'b0)       begin n_fail++; $display("FAIL reset_mispredict got %0b want 0", mispredict); end
      n_tests++; if (redirect_pc !== '0)        begin n_fail++; $display("FAIL reset_redirect_pc got %h want 0", redirect_pc); end
      n_tests++; if (count !== '0)              begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
      n_tests++; if (drop_count !== '0)         begin n_fail++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
   endtask

   task automatic test_basic_drain();
      logic [XLEN-1:0] pcs [3];
      logic            tk  [3];
      pcs = '{32'h100, 32'h104, 32'h108};
      tk  = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, tk[i], tk[i], pcs[i], 32'h0, 1);
         tick();
         n_tests++; if (upd_valid !== 1'b1)           begin n_fail++; $display("FAIL basic_valid[%0d] got %0b want 1", i, upd_valid); end
         n_tests++; if (upd_pc !== pcs[i])            begin n_fail++; $display("FAIL basic_pc[%0d] got %h want %h", i, upd_pc, pcs[i]); end
         n_tests++; if (branch_taken !== tk[i])       begin n_fail++; $display("FAIL basic_taken[%0d] got %0b want %0b", i, branch_taken, tk[i]); end
         n_tests++; if (branch_not_taken !== !tk[i])  begin n_fail++; $display("FAIL basic_not_taken[%0d] got %0b want %0b", i, branch_not_taken, !tk[i]); end
         n_tests++; if (mispredict !== 1'b0)          begin n_fail++; $display("FAIL basic_mispredict[%0d] got %0b want 0", i, mispredict); end
      end
      drive(0, 0, 0, 0, '0, '0, 1);
      tick();
      n_tests++; if (upd_valid !== 1'b0)                            begin n_fail++; $display("FAIL basic_empty_valid got %0b want 0", upd_valid); end
      n_tests++; if ({branch_taken, branch_not_taken} !== 2'b00)    begin n_fail++; $display("FAIL basic_empty_dir got %b want 00", {branch_taken, branch_not_taken}); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, i[0], i[0], 32'h300 + 32'(4 * i), 32'h0, 0);
         tick();
      end
      drive(0, 0, 0, 0, '0, '0, 0);
      n_tests++; if (count !== CW'(4))          begin n_fail++; $display("FAIL ovf_count got %0d want 4", count); end
      n_tests++; if (drop_count !== CNTW'(1))   begin n_fail++; $display("FAIL ovf_drop got %0d want 1", drop_count); end
      n_tests++; if (upd_pc !== 32'h300)        begin n_fail++; $display("FAIL ovf_head got %h want 300", upd_pc); end
      tick();
      n_tests++; if (upd_pc !== 32'h300)        begin n_fail++; $display("FAIL ovf_head_stable got %h want 300", upd_pc); end
   endtask

   task automatic test_full_cap_deq();
      logic [XLEN-1:0] heads [3];
      heads = '{32'h308, 32'h30C, 32'h400};
      drive(1, 1, 1, 1, 32'h400, 32'h0, 1);
      tick();
      n_tests++; if (count !== CW'(4))        begin n_fail++; $display("FAIL both_count got %0d want 4", count); end
      n_tests++; if (drop_count !== CNTW'(1)) begin n_fail++; $display("FAIL both_drop got %0d want 1", drop_count); end
      n_tests++; if (upd_pc !== 32'h304)      begin n_fail++; $display("FAIL both_head got %h want 304", upd_pc); end
      drive(0, 0, 0, 0, '0, '0, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++; if (upd_pc !== heads[i])   begin n_fail++; $display("FAIL both_pop[%0d] got %h want %h", i, upd_pc, heads[i]); end
      end
      n_tests++; if (branch_taken !== 1'b1)    begin n_fail++; $display("FAIL both_new_taken got %0b want 1", branch_taken); end
      tick();
      n_tests++; if (count !== '0)             begin n_fail++; $display("FAIL both_drained got %0d want 0", count); end
   endtask

   task automatic test_mispredict();
      drive(1, 1, 1, 0, 32'h200, 32'h380, 1);
      tick();
      n_tests++; if (mispredict !== 1'b1)     begin n_fail++; $display("FAIL mis_nt_pulse got %0b want 1", mispredict); end
      n_tests++; if (redirect_pc !== 32'h380) begin n_fail++; $display("FAIL mis_nt_redirect got %h want 380", redirect_pc); end
      drive(1, 1, 0, 1, 32'h200, 32'h380, 1);
      tick();
      n_tests++; if (mispredict !== 1'b1)     begin n_fail++; $display("FAIL mis_tn_pulse got %0b want 1", mispredict); end
      n_tests++; if (redirect_pc !== 32'h204) begin n_fail++; $display("FAIL mis_tn_redirect got %h want 204", redirect_pc); end
      drive(0, 0, 0, 0, '0, '0, 1);
      tick();
      n_tests++; if (mispredict !== 1'b0)     begin n_fail++; $display("FAIL mis_one_cycle got %0b want 0", mispredict); end
   endtask

   task automatic test_nonbranch();
      drive(1, 1, 0, 0, 32'h500, 32'h0, 0);
      tick();
      drive(1, 0, 1, 0, 32'h600, 32'h900, 0);
      tick();
      n_tests++; if (count !== CW'(1))    begin n_fail++; $display("FAIL nonbr_count got %0d want 1", count); end
      n_tests++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL nonbr_mispredict got %0b want 0", mispredict); end
      n_tests++; if (upd_pc !== 32'h500)  begin n_fail++; $display("FAIL nonbr_head got %h want 500", upd_pc); end
      drive(0, 0, 0, 0, '0, '0, 1);
      tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 1, (i != 2), 32'h700 + 32'(4 * i), 32'h7F0, 0);
         tick();
      end
      n_tests++; if (mispredict !== 1'b1 || count !== CW'(3)) begin n_fail++; $display("FAIL rstmid_pre got mis=%0b cnt=%0d want 1/3", mispredict, count); end
      reset = 1'b1;
      drive(1, 1, 1, 0, 32'h800, 32'h880, 1);
      tick();
      n_tests++; if ({upd_valid, branch_taken, branch_not_taken, mispredict} !== 4'b0000)
                    begin n_fail++; $display("FAIL rstmid_flags got %b want 0000", {upd_valid, branch_taken, branch_not_taken, mispredict}); end
      n_tests++; if (count !== '0 || drop_count !== '0 || redirect_pc !== '0)
                    begin n_fail++; $display("FAIL rstmid_regs got cnt=%0d drop=%0d red=%h want 0/0/0", count, drop_count, redirect_pc); end
      reset = 1'b0;
      drive(0, 0, 0, 0, '0, '0, 0);
      tick();
   endtask

   task automatic test_drop_saturate();
      for (int i = 0; i < DEPTH + DSAT + 5; i++) begin
         drive(1, 1, 0, 0, 32'(i * 4), 32'h0, 0);
         tick();
      end
      n_tests++; if (drop_count !== CNTW'(DSAT)) begin n_fail++; $display("FAIL sat_drop got %0d want %0d", drop_count, DSAT); end
      n_tests++; if (count !== CW'(DEPTH))       begin n_fail++; $display("FAIL sat_count got %0d want %0d", count, DEPTH); end
      n_tests++; if (upd_pc !== 32'h0)           begin n_fail++; $display("FAIL sat_head got %h want 0", upd_pc); end
   endtask

   task automatic test_random();
      logic            ev;
      logic [XLEN-1:0] rpc;
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(0, 49) == 0);
         rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom, 2'b00};
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
               $urandom_range(0, 1), rpc, $urandom, $urandom_range(0, 2) != 0);
         tick();
         ev = (mq.size() != 0);
         n_tests++; if (upd_valid !== ev)               begin n_fail++; $display("FAIL rnd_valid[%0d] got %0b want %0b", i, upd_valid, ev); end
         n_tests++; if (count !== CW'(mq.size()))       begin n_fail++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, count, mq.size()); end
         n_tests++; if (drop_count !== CNTW'(m_drop))   begin n_fail++; $display("FAIL rnd_drop[%0d] got %0d want %0d", i, drop_count, m_drop); end
         n_tests++; if (mispredict !== m_mis)           begin n_fail++; $display("FAIL rnd_mis[%0d] got %0b want %0b", i, mispredict, m_mis); end
         if (m_mis) begin
            n_tests++; if (redirect_pc !== m_red)       begin n_fail++; $display("FAIL rnd_redirect[%0d] got %h want %h", i, redirect_pc, m_red); end
         end
         if (ev) begin
            n_tests++; if (upd_pc !== mq[0].pc)         begin n_fail++; $display("FAIL rnd_pc[%0d] got %h want %h", i, upd_pc, mq[0].pc); end
            n_tests++; if ({branch_taken, branch_not_taken} !== {mq[0].taken, !mq[0].taken})
                          begin n_fail++; $display("FAIL rnd_dir[%0d] got %b want %b", i, {branch_taken, branch_not_taken}, {mq[0].taken, !mq[0].taken}); end
         end else begin
            n_tests++; if ({branch_taken, branch_not_taken} !== 2'b00)
                          begin n_fail++; $display("FAIL rnd_dir_empty[%0d] got %b want 00", i, {branch_taken, branch_not_taken}); end
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, '0, '0, 0);
      m_drop = 0;
      m_mis  = 1'b0;
      m_red  = '0;
      @(negedge clock);
      test_reset();
      test_basic_drain();
      test_overflow();
      test_full_cap_deq();
      test_mispredict();
      test_nonbranch();
      test_reset_mid();
      test_drop_saturate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
